// File: rtl/irq_aggregator_pkg.sv
// Shared constants for the interrupt aggregator: register map, data width and
// the source-count ceiling.
package irq_aggregator_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MAX_SRC = 15;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_HIGHEST = 3'd3;
  localparam logic [2:0] ADDR_OVERRUN = 3'd4;
  localparam logic [2:0] ADDR_FORCE   = 3'd5;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one interrupt source plus a delayed copy used for
// rising-edge detection.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic level,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source edge/level capture, masking,
// overrun tracking and a lowest-index priority readout.
module irq_aggregator
  import irq_aggregator_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  irq_src,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                irq
);

  logic [NUM_SRC-1:0] s2, rise;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overrun_q, overrun_d;
  logic [NUM_SRC-1:0] mask_q, mode_q;
  logic [NUM_SRC-1:0] wdata, clr_pending, clr_overrun, force_bits, active;
  logic               wr_en;
  logic               active_any;
  logic [3:0]         highest_idx;
  logic [DATA_W-1:0]  rd_mux;
  logic               unused_wdata;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .src   (irq_src[i]),
      .level (s2[i]),
      .rise  (rise[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[NUM_SRC-1:0];
  assign unused_wdata = ^writedata[DATA_W-1:NUM_SRC];

  assign clr_pending = (wr_en && address == ADDR_PENDING) ? wdata : '0;
  assign clr_overrun = (wr_en && address == ADDR_OVERRUN) ? wdata : '0;
  assign force_bits  = (wr_en && address == ADDR_FORCE)   ? wdata : '0;

  // Set terms are OR'd after the clear so a same-cycle set always wins.
  always_comb begin
    pending_d = (mode_q & (rise | force_bits | (pending_q & ~clr_pending)))
              | (~mode_q & (s2 | force_bits));
    overrun_d = (mode_q & rise & pending_q & ~clr_pending)
              | (overrun_q & ~clr_overrun);
  end

  assign active     = pending_q & mask_q;
  assign active_any = |active;

  // Scan downwards so the last assignment is the lowest active index.
  always_comb begin
    highest_idx = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) highest_idx = 4'(i);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_PENDING: rd_mux[NUM_SRC-1:0] = pending_q;
      ADDR_MASK:    rd_mux[NUM_SRC-1:0] = mask_q;
      ADDR_MODE:    rd_mux[NUM_SRC-1:0] = mode_q;
      ADDR_HIGHEST: rd_mux = {active_any, 11'd0, highest_idx};
      ADDR_OVERRUN: rd_mux[NUM_SRC-1:0] = overrun_q;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      overrun_q <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      readdata  <= '0;
      irq       <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      if (wr_en && address == ADDR_MASK) mask_q <= wdata;
      if (wr_en && address == ADDR_MODE) mode_q <= wdata;
      readdata  <= rd_mux;
      irq       <= active_any;
    end
  end

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed bench for irq_aggregator: register-map table plus hand-timed
// sequences for latency, overrun, set/clear races, level mode and reset.
module tb_irq_aggregator;
  import irq_aggregator_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_src = '0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  irq_aggregator #(.NUM_SRC(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    irq_src = m;
    @(negedge clk);
    irq_src = '0;
    repeat (3) @(negedge clk);
  endtask

  logic [15:0] rd;

  initial begin
    // Register-map table: reset values, out-of-range bits, unmapped addresses.
    vecs[0]  = '{1'b0, ADDR_PENDING, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, ADDR_MASK,    16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, ADDR_MODE,    16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, ADDR_HIGHEST, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, ADDR_OVERRUN, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, ADDR_FORCE,   16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 3'd6,         16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 3'd7,         16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, ADDR_MASK,    16'hFFFF, 16'h0000};
    vecs[9]  = '{1'b0, ADDR_MASK,    16'h0000, 16'h00FF};
    vecs[10] = '{1'b1, ADDR_MODE,    16'h00A5, 16'h0000};
    vecs[11] = '{1'b0, ADDR_MODE,    16'h0000, 16'h00A5};
    vecs[12] = '{1'b1, 3'd6,         16'hFFFF, 16'h0000};
    vecs[13] = '{1'b0, 3'd6,         16'h0000, 16'h0000};
    vecs[14] = '{1'b1, ADDR_MODE,    16'h0000, 16'h0000};
    vecs[15] = '{1'b1, ADDR_MASK,    16'h0000, 16'h0000};

    repeat (2) @(negedge clk);
    check("reset_irq", {15'd0, irq}, 16'h0000);
    check("reset_readdata", readdata, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data);
      end else begin
        do_read(vecs[i].addr, rd);
        check($sformatf("table_read_%0d", i), rd, vecs[i].exp);
      end
    end

    // Edge mode latency: irq three edges after the first sampling edge.
    do_write(ADDR_MODE, 16'h0001);
    do_write(ADDR_MASK, 16'h0001);
    @(negedge clk);
    irq_src = 8'h01;
    @(posedge clk);
    @(negedge clk);
    irq_src = 8'h00;
    @(posedge clk);
    @(posedge clk); #1;
    check("edge_irq_k2", {15'd0, irq}, 16'h0000);
    @(posedge clk); #1;
    check("edge_irq_k3", {15'd0, irq}, 16'h0001);
    do_read(ADDR_PENDING, rd);
    check("edge_pending", rd, 16'h0001);
    do_read(ADDR_HIGHEST, rd);
    check("edge_highest", rd, 16'h8000);
    do_write(ADDR_PENDING, 16'h0001);
    check("w1c_irq_first_edge", {15'd0, irq}, 16'h0001);
    @(posedge clk); #1;
    check("w1c_irq_second_edge", {15'd0, irq}, 16'h0000);

    // Overrun on a second rise before the clear.
    pulse(8'h01);
    pulse(8'h01);
    do_read(ADDR_OVERRUN, rd);
    check("overrun_set", rd, 16'h0001);
    do_read(ADDR_PENDING, rd);
    check("overrun_pending", rd, 16'h0001);
    do_write(ADDR_OVERRUN, 16'h0001);
    do_read(ADDR_OVERRUN, rd);
    check("overrun_clear", rd, 16'h0000);
    do_write(ADDR_PENDING, 16'h0001);
    do_read(ADDR_PENDING, rd);
    check("pending_clear", rd, 16'h0000);

    // Rise on bit 2 coinciding with a W1C of bit 2: set wins, no overrun.
    do_write(ADDR_MODE, 16'h0005);
    do_write(ADDR_FORCE, 16'h0004);
    @(negedge clk);
    irq_src = 8'h04;
    @(negedge clk);
    @(negedge clk);
    address = ADDR_PENDING; chipselect = 1'b1; write_n = 1'b0; writedata = 16'h0004;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    do_read(ADDR_PENDING, rd);
    check("race_pending", rd, 16'h0004);
    do_read(ADDR_OVERRUN, rd);
    check("race_overrun", rd, 16'h0000);
    irq_src = 8'h00;

    // Level mode: held sources, priority readout, ineffective W1C.
    do_write(ADDR_MODE, 16'h0000);
    do_write(ADDR_MASK, 16'h00FF);
    @(negedge clk);
    irq_src = 8'h28;
    repeat (4) @(negedge clk);
    do_read(ADDR_HIGHEST, rd);
    check("level_highest", rd, 16'h8003);
    do_read(ADDR_PENDING, rd);
    check("level_pending", rd, 16'h0028);
    do_write(ADDR_PENDING, 16'h0028);
    do_read(ADDR_PENDING, rd);
    check("level_w1c_noeffect", rd, 16'h0028);
    check("level_irq", {15'd0, irq}, 16'h0001);
    @(negedge clk);
    irq_src = 8'h00;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    check("level_drop_k2", {15'd0, irq}, 16'h0001);
    @(posedge clk); #1;
    check("level_drop_k3", {15'd0, irq}, 16'h0000);
    do_read(ADDR_PENDING, rd);
    check("level_drop_pending", rd, 16'h0000);

    // FORCE in edge mode, then asynchronous reset mid-cycle.
    do_write(ADDR_MODE, 16'h0080);
    do_write(ADDR_MASK, 16'h0080);
    do_write(ADDR_FORCE, 16'h0080);
    check("force_irq_first_edge", {15'd0, irq}, 16'h0000);
    @(posedge clk); #1;
    check("force_irq_second_edge", {15'd0, irq}, 16'h0001);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_irq", {15'd0, irq}, 16'h0000);
    check("async_reset_readdata", readdata, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    do_read(ADDR_PENDING, rd);
    check("post_reset_pending", rd, 16'h0000);
    do_read(ADDR_MASK, rd);
    check("post_reset_mask", rd, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_aggregator.md
IRQ_AGGREGATOR -- requirements
Module: irq_aggregator

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, meaning number of interrupt sources (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit, the single clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port irq_src, input, NUM_SRC bits, raw interrupt requests, bit 0 = timer irq; may be asynchronous to clk.
REQ-005 SHALL have port address, input, 3 bits, Avalon-MM word address.
REQ-006 SHALL have port chipselect, input, 1 bit, slave select.
REQ-007 SHALL have port write_n, input, 1 bit, active-low write strobe.
REQ-008 SHALL have port writedata, input, 16 bits, write data.
REQ-009 SHALL have port readdata, output, 16 bits, registered read data.
REQ-010 SHALL have port irq, output, 1 bit, registered aggregate interrupt to the CPU.

Function
REQ-011 SHALL synchronise each irq_src bit through two flops (s1, s2) and keep a delayed copy s3 of s2.
REQ-012 SHALL define rise[i] = s2[i] & ~s3[i].
REQ-013 SHALL implement the register map: 0 PENDING, 1 MASK, 2 MODE, 3 HIGHEST, 4 OVERRUN, 5 FORCE; addresses 6 and 7 read 0 and ignore writes.
REQ-014 SHALL in edge mode (MODE[i]=1) set pending[i] on rise[i], on a FORCE write with bit i = 1, or both; pending[i] holds until cleared.
REQ-015 SHALL in edge mode clear pending[i] when a write to PENDING has writedata[i]=1 (write-1-to-clear).
REQ-016 SHALL resolve a same-cycle set and clear of pending[i] as set wins.
REQ-017 SHALL in level mode (MODE[i]=0) register pending[i] <= s2[i] | FORCE-write bit i every cycle; PENDING write-1-to-clear has no effect in level mode.
REQ-018 SHALL in edge mode set overrun[i] when rise[i] occurs while pending[i]=1 and pending[i] is not being cleared in that cycle.
REQ-019 SHALL clear overrun[i] by a write-1 to OVERRUN[i]; a same-cycle set and clear leaves overrun[i] set.
REQ-020 SHALL accept writes only when chipselect=1 and write_n=0; bits at or above NUM_SRC are ignored on write and read as 0.
REQ-021 SHALL have MASK and MODE as read/write registers; FORCE reads 0.
REQ-022 SHALL define active = pending & MASK.
REQ-023 SHALL return from HIGHEST: bit15 = |active, bits[3:0] = lowest index i with active[i]=1, all other bits 0; bits[3:0] read 0 when no bit is active.
REQ-024 SHALL register irq <= |active, so irq asserts one cycle after pending and mask are both set.
REQ-025 SHALL meet this latency for an irq_src level first sampled high at edge k: s2 at k+1, pending at k+2, irq at k+3, in both edge and level mode.
REQ-026 SHALL register readdata <= read mux(address) every cycle regardless of chipselect, giving one-cycle read latency.
REQ-027 SHALL make reads side-effect free.
REQ-028 SHALL make a write to MASK that zeroes all active bits drop irq at the next edge.

Reset
REQ-029 SHALL, on reset assertion, asynchronously clear s1, s2, s3, pending, overrun, MASK, MODE (all level mode), readdata and irq to 0.
REQ-030 SHALL on reset deassertion discard nothing beyond the cleared state; a source already high after reset produces rise (edge mode) once s2 goes high.
REQ-031 SHALL on a reset mid-operation drop a pending interrupt immediately, with irq=0 in the same cycle, without waiting for a clock.

Structure
REQ-032 SHALL take address constants (ADDR_PENDING..ADDR_FORCE), the data width of 16 and the NUM_SRC maximum of 15 from a shared package irq_aggregator_pkg.
REQ-033 SHALL put per-source synchronisation and edge detection (s1/s2/s3, rise) in sub-module irq_sync_edge, instantiated NUM_SRC times.
REQ-034 SHALL keep the priority encoder combinational inside irq_aggregator.

Verification
REQ-035 SHALL cover: MODE=0x01, MASK=0x01, pulse irq_src[0] high for 1 cycle -> pending[0]=1 at k+2, irq=1 at k+3; write PENDING=0x0001 -> irq=0 two edges later.
REQ-036 SHALL cover: edge mode, second rise on bit 0 before clear -> OVERRUN reads 0x0001; write OVERRUN=0x0001 -> reads 0x0000.
REQ-037 SHALL cover: rise on bit 2 in the same cycle as a W1C of bit 2 -> pending[2] remains 1, overrun[2] remains 0.
REQ-038 SHALL cover: level mode, MASK=0xFF, irq_src=0x28 held -> HIGHEST reads 0x8003; drop irq_src -> pending=0 and irq=0 after 3 cycles; W1C has no effect while the source is held.
REQ-039 SHALL cover: FORCE write 0x0080 with MASK=0x80 -> irq=1 two edges after the write; assert reset mid-cycle -> irq=0, PENDING/MASK read 0.
REQ-040 SHALL cover: read address 6 -> readdata=0x0000; write MASK=0xFFFF with NUM_SRC=8 -> MASK reads 0x00FF.
